// File: rtl/traffic_phase_scheduler.sv
// Actuated phase scheduler for one four-way intersection (NS, EW, pedestrian).
// Latency: lamps are Moore-decoded from the state register; requests act on the next clk edge.
// Backpressure: none; requests are levels (ped_btn latched) and wait for round-robin service.
// Ports: clk_50MHz/reset (async, active-high); ns_car/ew_car/ped_btn requests;
//        NS_Light/EW_Light {R,Y,G}, walk lamp, ped_pend latch, phase debug code.
module traffic_phase_scheduler #(
  parameter int unsigned GREEN_MIN = 250_000_000,
  parameter int unsigned GREEN_MAX = 750_000_000,
  parameter int unsigned YELLOW_T  = 100_000_000,
  parameter int unsigned ALLRED_T  = 50_000_000,
  parameter int unsigned WALK_T    = 350_000_000,
  parameter int unsigned TW        = 32
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_btn,
  output logic [2:0] NS_Light,
  output logic [2:0] EW_Light,
  output logic       walk,
  output logic       ped_pend,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR   = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    WALK = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    NS_SRV   = 2'd0,
    EW_SRV   = 2'd1,
    WALK_SRV = 2'd2
  } srv_e;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // Terminal timer values: a timed state leaves on the edge where timer == T-1.
  localparam logic [TW-1:0] GMIN_END = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] GMAX_END = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] YEL_END  = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] AR_END   = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] WALK_END = TW'(WALK_T - 1);

  state_e        state_q, state_d;
  srv_e          last_q, last_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ped_pend_q, ped_pend_d;

  // Round-robin grant: search starts just after the last-served phase in the
  // cyclic order NS -> EW -> WALK; with nothing requested, rest in NS green.
  function automatic state_e arbitrate(input srv_e last, input logic n_req,
                                       input logic e_req, input logic p_req);
    state_e g;
    g = NS_G;
    case (last)
      NS_SRV: begin
        if (e_req)      g = EW_G;
        else if (p_req) g = WALK;
        else            g = NS_G;
      end
      EW_SRV: begin
        if (p_req)      g = WALK;
        else if (n_req) g = NS_G;
        else if (e_req) g = EW_G;
      end
      default: begin
        if (n_req)      g = NS_G;
        else if (e_req) g = EW_G;
        else if (p_req) g = WALK;
      end
    endcase
    return g;
  endfunction

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      NS_G: begin
        if ((ew_car | ped_pend_q) &&
            ((timer_q >= GMIN_END && !ns_car) || timer_q >= GMAX_END))
          state_d = NS_Y;
      end
      EW_G: begin
        if ((ns_car | ped_pend_q) &&
            ((timer_q >= GMIN_END && !ew_car) || timer_q >= GMAX_END))
          state_d = EW_Y;
      end
      NS_Y, EW_Y: if (timer_q >= YEL_END)  state_d = AR;
      WALK:       if (timer_q >= WALK_END) state_d = AR;
      AR: begin
        if (timer_q >= AR_END)
          state_d = arbitrate(last_q, ns_car, ew_car, ped_pend_q);
      end
      default: begin
        // Corrupted state code: clear the junction and let NS win next.
        state_d = AR;
        last_d  = WALK_SRV;
      end
    endcase

    if (state_d != state_q) begin
      case (state_d)
        NS_G:    last_d = NS_SRV;
        EW_G:    last_d = EW_SRV;
        WALK:    last_d = WALK_SRV;
        default: ;
      endcase
    end

    // Timer restarts on every state change and otherwise saturates.
    if (state_d != state_q)  timer_d = '0;
    else if (timer_q != '1)  timer_d = timer_q + 1'b1;
    else                     timer_d = timer_q;

    // Entering WALK serves the request and beats a same-cycle press.
    ped_pend_d = ped_pend_q;
    if (state_d == WALK && state_q != WALK) ped_pend_d = 1'b0;
    else if (ped_btn && state_q != WALK)    ped_pend_d = 1'b1;
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_q    <= AR;
      last_q     <= WALK_SRV;
      timer_q    <= '0;
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      timer_q    <= timer_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  always_comb begin
    NS_Light = LAMP_R;
    EW_Light = LAMP_R;
    walk     = 1'b0;
    case (state_q)
      NS_G:    NS_Light = LAMP_G;
      NS_Y:    NS_Light = LAMP_Y;
      EW_G:    EW_Light = LAMP_G;
      EW_Y:    EW_Light = LAMP_Y;
      WALK:    walk     = 1'b1;
      default: ;
    endcase
  end

  assign ped_pend = ped_pend_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler with short interval overrides.
// Latency: model advances on each rising edge; DUT compared 1 ns later.
// Backpressure: not applicable; inputs are free-running levels and pulses.
module tb_traffic_phase_scheduler;

  localparam int GMIN = 8;
  localparam int GMAX = 20;
  localparam int YEL  = 3;
  localparam int ART  = 2;
  localparam int WLK  = 6;

  logic       clk_50MHz = 1'b0;
  logic       reset;
  logic       ns_car, ew_car, ped_btn;
  logic [2:0] NS_Light, EW_Light, phase;
  logic       walk, ped_pend;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase code, cycles spent in phase, last served
  // requester (0 NS, 1 EW, 2 WALK) and the latched pedestrian request.
  int m_ph, m_t, m_last;
  bit m_pend;

  traffic_phase_scheduler #(
    .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YEL),
    .ALLRED_T(ART), .WALK_T(WLK), .TW(8)
  ) dut (
    .clk_50MHz(clk_50MHz), .reset(reset),
    .ns_car(ns_car), .ew_car(ew_car), .ped_btn(ped_btn),
    .NS_Light(NS_Light), .EW_Light(EW_Light), .walk(walk),
    .ped_pend(ped_pend), .phase(phase)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 2; m_t = 0; m_last = 2; m_pend = 0;
  endtask

  task automatic model_step();
    int  nxt;
    bit  req [3];
    if (reset) begin
      model_reset();
      return;
    end
    nxt = m_ph;
    case (m_ph)
      0: if ((ew_car || m_pend) && ((m_t >= GMIN-1 && !ns_car) || m_t >= GMAX-1)) nxt = 1;
      3: if ((ns_car || m_pend) && ((m_t >= GMIN-1 && !ew_car) || m_t >= GMAX-1)) nxt = 4;
      1: if (m_t == YEL-1) nxt = 2;
      4: if (m_t == YEL-1) nxt = 2;
      5: if (m_t == WLK-1) nxt = 2;
      default: if (m_t == ART-1) begin
        req[0] = ns_car; req[1] = ew_car; req[2] = m_pend;
        nxt = 0;
        for (int k = 3; k >= 1; k--)
          if (req[(m_last + k) % 3]) nxt = ((m_last + k) % 3) * 3 - (((m_last + k) % 3 == 2) ? 1 : 0);
      end
    endcase
    if (nxt == 5 && m_ph != 5)        m_pend = 0;
    else if (ped_btn && m_ph != 5)    m_pend = 1;
    if (nxt != m_ph) begin
      if (nxt == 0) m_last = 0;
      if (nxt == 3) m_last = 1;
      if (nxt == 5) m_last = 2;
      m_t = 0;
    end else begin
      m_t++;
    end
    m_ph = nxt;
  endtask

  task automatic compare_all(input string tag);
    logic [2:0] ns_exp, ew_exp;
    ns_exp = (m_ph == 0) ? 3'b001 : (m_ph == 1) ? 3'b010 : 3'b100;
    ew_exp = (m_ph == 3) ? 3'b001 : (m_ph == 4) ? 3'b010 : 3'b100;
    chk({tag, "_ns"},    32'(NS_Light), 32'(ns_exp));
    chk({tag, "_ew"},    32'(EW_Light), 32'(ew_exp));
    chk({tag, "_walk"},  32'(walk),     32'(m_ph == 5));
    chk({tag, "_pend"},  32'(ped_pend), 32'(m_pend));
    chk({tag, "_phase"}, 32'(phase),    32'(m_ph));
    chk({tag, "_safe"},
        32'((NS_Light != 3'b100 && EW_Light != 3'b100) ||
            (walk && (NS_Light != 3'b100 || EW_Light != 3'b100))), 32'(0));
  endtask

  task automatic tick(input string tag);
    @(posedge clk_50MHz);
    model_step();
    #1 compare_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  // Bounded wait on the DUT reaching a phase; a timeout is a failed check.
  task automatic run_until_phase(input string tag, input int ph, input int budget);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick(tag);
      if (phase == 3'(ph)) hit = 1;
    end
    chk({tag, "_reach"}, 32'(hit), 32'(1));
  endtask

  initial begin
    int cnt;
    bit hit;
    reset = 1'b1; ns_car = 0; ew_car = 0; ped_btn = 0;
    model_reset();
    run("rst", 3);

    // 1: idle after reset -> 2 cycles AR then NS green at rest; long enough to saturate.
    reset = 1'b0;
    run("s1", 300);
    chk("s1_rest_ns", 32'(NS_Light), 32'(3'b001));
    chk("s1_rest_ew", 32'(EW_Light), 32'(3'b100));

    // 2: EW car arrives against a saturated NS green.
    ew_car = 1;
    cnt = 0; hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick("s2");
      cnt++;
      if (EW_Light == 3'b001) hit = 1;
    end
    chk("s2_ew_latency", 32'(cnt), 32'(6));
    run("s2", 30);

    // 3: both directions demand continuously -> max-green alternation.
    ns_car = 1;
    run("s3", 120);

    // 4: pedestrian pulse during EW green with NS waiting -> WALK served first.
    ns_car = 0; ew_car = 1;
    run_until_phase("s4a", 3, 80);
    ns_car = 1; ew_car = 0;
    ped_btn = 1;
    tick("s4");
    ped_btn = 0;
    chk("s4_pend", 32'(ped_pend), 32'(1));
    run_until_phase("s4w", 5, 60);
    chk("s4_walk", 32'(walk), 32'(1));
    chk("s4_pend_clr", 32'(ped_pend), 32'(0));
    run("s4", 30);

    // 5: button held through WALK.
    ped_btn = 1;
    run_until_phase("s5w", 5, 100);
    run("s5", 15);
    ped_btn = 0;
    run("s5", 20);

    // 6: async reset in the middle of EW yellow.
    ns_car = 0; ew_car = 1;
    run_until_phase("s6g", 3, 100);
    ns_car = 1; ew_car = 0;
    run_until_phase("s6y", 4, 60);
    tick("s6");
    #2 reset = 1'b1;
    #1;
    chk("s6_async_ns", 32'(NS_Light), 32'(3'b100));
    chk("s6_async_ew", 32'(EW_Light), 32'(3'b100));
    chk("s6_async_walk", 32'(walk), 32'(0));
    chk("s6_async_phase", 32'(phase), 32'(2));
    model_reset();
    run("s6r", 2);
    reset = 1'b0; ns_car = 0;
    run("s6", 10);

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 14) == 0) ns_car = ~ns_car;
      if ($urandom_range(0, 14) == 0) ew_car = ~ew_car;
      ped_btn = ($urandom_range(0, 24) == 0);
      reset   = ($urandom_range(0, 599) == 0);
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
